// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per SCAN cycle, signed or unsigned.
// Optional macro EARLY_EXIT_EN ends the scan at the first differing digit.
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb
);

    localparam int unsigned S    = WIDTH / DIGIT;
    localparam int unsigned CntW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aeqb_q, aeqb_d;
    logic             agtb_q, agtb_d;
    logic             altb_q, altb_d;

    logic [DIGIT-1:0] dig_a, dig_b;
    logic             undecided, new_gt, new_lt, last, scan_exit;
    logic [WIDTH-1:0] msb_flip;

    always_comb begin
        dig_a     = a_sh_q[WIDTH-1 -: DIGIT];
        dig_b     = b_sh_q[WIDTH-1 -: DIGIT];
        undecided = !gt_q && !lt_q;
        new_gt    = gt_q || (undecided && (dig_a > dig_b));
        new_lt    = lt_q || (undecided && (dig_a < dig_b));
        last      = (cnt_q == CntW'(S - 1));
`ifdef EARLY_EXIT_EN
        scan_exit = last || new_gt || new_lt;
`else
        scan_exit = last;
`endif
        // Biasing both operands by flipping the MSB turns a signed compare into an unsigned one.
        msb_flip  = {signed_mode, {(WIDTH-1){1'b0}}};
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        aeqb_d  = aeqb_q;
        agtb_d  = agtb_q;
        altb_d  = altb_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a ^ msb_flip;
                    b_sh_d  = b ^ msb_flip;
                    cnt_d   = '0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                a_sh_d = a_sh_q << DIGIT;
                b_sh_d = b_sh_q << DIGIT;
                gt_d   = new_gt;
                lt_d   = new_lt;
                cnt_d  = cnt_q + 1'b1;
                if (scan_exit) begin
                    aeqb_d  = !new_gt && !new_lt;
                    agtb_d  = new_gt;
                    altb_d  = new_lt;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            agtb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            aeqb_q  <= aeqb_d;
            agtb_q  <= agtb_d;
            altb_q  <= altb_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign aeqb = aeqb_q;
    assign agtb = agtb_q;
    assign altb = altb_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised self-checking bench for seq_magnitude_comparator (DIGIT=1 and DIGIT=4 instances).
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       st1, sm1, busy1, done1, eq1, gt1, lt1;
    logic [7:0] a1, b1;
    logic       st4, sm4, busy4, done4, eq4, gt4, lt4;
    logic [7:0] a4, b4;

    int checks = 0;
    int errors = 0;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .signed_mode(sm1),
        .busy(busy1), .done(done1), .aeqb(eq1), .agtb(gt1), .altb(lt1)
    );

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .signed_mode(sm4),
        .busy(busy4), .done(done4), .aeqb(eq4), .agtb(gt4), .altb(lt4)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic sm);
        if (sel == 1) begin
            st1 = st; a1 = a; b1 = b; sm1 = sm;
        end else begin
            st4 = st; a4 = a; b4 = b; sm4 = sm;
        end
    endtask

    function automatic logic [4:0] outs(input int sel);
        if (sel == 1) return {busy1, done1, eq1, gt1, lt1};
        else return {busy4, done4, eq4, gt4, lt4};
    endfunction

    // Reference: integer compare, latency from position of the highest differing (biased) bit.
    function automatic int ref_cmp(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int va, vb;
        va = sm ? int'($signed(a)) : int'(a);
        vb = sm ? int'($signed(b)) : int'(b);
        if (va > vb) return 2;
        if (va < vb) return 1;
        return 4;
    endfunction

    function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                   input int d);
        int va, vb, x, p;
        va = sm ? int'($signed(a)) + 128 : int'(a);
        vb = sm ? int'($signed(b)) + 128 : int'(b);
        x  = va ^ vb;
`ifdef EARLY_EXIT_EN
        if (x == 0) return 8 / d;
        p = 0;
        for (int i = 0; i < 8; i++) if (x[i]) p = i;
        return (7 - p) / d + 1;
`else
        p = x;
        return 8 / d;
`endif
    endfunction

    task automatic do_cmp(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input bit disturb, input string tag);
        int n, d, lat, res;
        bit got;
        logic [4:0] o;
        d   = (sel == 1) ? 1 : 4;
        lat = ref_lat(a, b, sm, d);
        res = ref_cmp(a, b, sm);
        @(negedge clk);
        drive(sel, 1'b1, a, b, sm);
        @(posedge clk);
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (disturb && n == 1) drive(sel, 1'b1, ~a, ~b, ~sm);
            else drive(sel, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
            @(posedge clk);
            n++;
            #1;
            o = outs(sel);
            if (o[3]) got = 1;
        end
        check({tag, " done_seen"}, int'(got), 1);
        check({tag, " latency"}, n, lat);
        o = outs(sel);
        check({tag, " flags"}, int'(o[2:0]), res);
        check({tag, " busy_in_done"}, int'(o[4]), 1);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        o = outs(sel);
        check({tag, " done_pulse_end"}, int'(o[4:3]), 0);
        check({tag, " flags_hold"}, int'(o[2:0]), res);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [4:0] o;
        int         seen;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_outs1", int'(outs(1)), 0);
        check("reset_outs4", int'(outs(4)), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_cmp(1, 8'h80, 8'h7F, 1'b0, 0, "u80_7f");
        do_cmp(1, 8'h80, 8'h7F, 1'b1, 0, "s80_7f");
        do_cmp(1, 8'hFF, 8'hFE, 1'b1, 0, "sff_fe");
        do_cmp(1, 8'h5A, 8'h5A, 1'b0, 0, "eq5a");
        do_cmp(1, 8'h01, 8'h00, 1'b0, 0, "lsb01");
        do_cmp(4, 8'h3C, 8'h3D, 1'b0, 1, "d4_3c_3d");

        // Abort a compare mid-scan; flags from the previous result must clear at once.
        @(negedge clk);
        drive(1, 1'b1, 8'h5A, 8'h5A, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outs", int'(outs(1)), 0);
        check("abort_outs4", int'(outs(4)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            o = outs(1);
            if (o[3] || o[4]) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_flags", int'(outs(1)), 0);
        do_cmp(1, 8'h10, 8'h20, 1'b0, 0, "after_abort");

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 4) == 0) ? ra : 8'($urandom_range(0, 255));
            do_cmp(1, ra, rb, 1'($urandom), 0, "rand1");
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 4) == 0) ? ra : 8'($urandom_range(0, 255));
            do_cmp(4, ra, rb, 1'($urandom), 1'($urandom), "rand4");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Operands are captured on a start handshake and scanned MSB-first, DIGIT bits per cycle.
- Produces registered one-hot eq/gt/lt flags and a one-cycle done pulse.
- Successor to the team's combinational 4-bit comparator. Adds arbitrary width, signed/unsigned mode and a start/busy/done interface, so wide compares meet timing in the lab datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 2.
- DIGIT, 1, bits compared per SCAN cycle; WIDTH must be an integer multiple of DIGIT. Any other value is an illegal configuration and is not verified.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; sampled only in IDLE.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse: new result valid.
- aeqb  out  1  registered result A == B.
- agtb  out  1  registered result A > B.
- altb  out  1  registered result A < B.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, busy=0, done=0, aeqb=agtb=altb=0 (no valid result). Reset asserted mid-operation aborts the compare immediately, with no done pulse.
- States: IDLE, SCAN, DONE. Define S = WIDTH/DIGIT.
- IDLE:
  - start=1 at an edge captures a, b and signed_mode into shift registers and clears the running decision; next state is SCAN.
  - If signed_mode=1, the MSB of both captured operands is inverted. The scan itself is always unsigned.
- SCAN:
  - Each cycle compares the top DIGIT bits of both shift registers, then shifts both left by DIGIT.
  - The first unequal digit latches the decision (gt or lt). Later digits cannot change it.
  - A counter runs 0..S-1. At count S-1 the next state is DONE.
- DONE:
  - Lasts exactly 1 cycle; done=1, then the state returns to IDLE.
  - The result flags load on the edge that enters DONE: exactly one of aeqb/agtb/altb is 1. aeqb=1 only if no digit differed.
  - The flags hold until the edge that enters the next DONE, or until reset. They are not cleared on start.
- Latency: start sampled at edge 0 → result flags update and done rises after edge S. Throughput is one compare per S+2 cycles.
- start while busy=1 (SCAN or DONE) is ignored; operands presented then are not captured. start held high continuously re-triggers on each return to IDLE.
- Inputs a, b and signed_mode may change freely after capture without affecting the result.
- done and busy are registered outputs (no combinational path from start).

Optional Feature:
- Macro: EARLY_EXIT_EN.
- Defined: SCAN exits to DONE on the cycle the first unequal digit is found, or at count S-1 if none differs. Latency is variable, 1..S cycles from the start edge to the result.
- Undefined: latency is fixed at S, regardless of data.
- Results are identical in both builds; only timing differs.

Test Plan:
- Reset → assert rst_n=0 asynchronously mid-cycle → busy=0, done=0, all flags 0 without waiting for a clock edge.
- WIDTH=8, DIGIT=1, unsigned a=0x80, b=0x7F, start pulse → agtb=1, aeqb=altb=0. done pulses exactly 8 cycles after the start edge (no macro) or 1 cycle (EARLY_EXIT_EN).
- Same operands, signed_mode=1 (−128 vs 127) → altb=1. Then a=0xFF, b=0xFE signed → agtb=1.
- a=b=0x5A → aeqb=1, done after 8 cycles in both builds. a=0x01, b=0x00 → agtb=1, 8 cycles in both builds (difference in LSB digit).
- WIDTH=8, DIGIT=4, a=0x3C, b=0x3D → altb=1, done 2 cycles after start. Change a/b and pulse start while busy=1 → ignored; result still altb=1.
- Start a compare, assert rst_n=0 during SCAN, release → no done pulse, flags 0, busy 0. A new start with a=0x10, b=0x20 completes normally with altb=1.
